// File: rtl/sprite_rom.sv
// sprite_rom: draws one multi-colour sprite of SPR_WIDTH x SPR_HEIGHT from a synchronous
// bitmap memory with power-of-two scaling. Define SPRITE_FLIP_EN to add hflip/vflip inputs.
module sprite_rom #(
    parameter int CORDW      = 16,
    parameter int H_RES      = 640,
    parameter int SX_OFFS    = 3,
    parameter int SPR_WIDTH  = 8,
    parameter int SPR_HEIGHT = 8,
    parameter int COLRW      = 4,
    parameter int SPR_SCALE  = 0,
    parameter int ADDRW      = $clog2(SPR_WIDTH*SPR_HEIGHT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic signed [CORDW-1:0] sprx,
    input  logic signed [CORDW-1:0] spry,
    input  logic [COLRW-1:0]        data_in,
`ifdef SPRITE_FLIP_EN
    input  logic                    hflip,
    input  logic                    vflip,
`endif
    output logic [ADDRW-1:0]        pos,
    output logic [COLRW-1:0]        pix,
    output logic                    drawing
);

    localparam int CW = CORDW + 1;
    localparam int XW = $clog2(SPR_WIDTH);
    localparam int YW = (SPR_HEIGHT > 1) ? $clog2(SPR_HEIGHT) : 1;
    localparam int SW = (SPR_SCALE > 0) ? SPR_SCALE : 1;

    localparam logic [SW-1:0]        CNT_MAX  = SW'((1 << SPR_SCALE) - 1);
    localparam logic [XW-1:0]        X_LAST   = XW'(SPR_WIDTH - 1);
    localparam logic signed [CW-1:0] OFFS     = CW'(SX_OFFS);
    localparam logic signed [CW-1:0] H_RES_S  = CW'(H_RES);
    localparam logic signed [CW-1:0] H_END    = CW'(H_RES - SX_OFFS);
    localparam logic signed [CW-1:0] SPR_W_PX = CW'(SPR_WIDTH << SPR_SCALE);
    localparam logic signed [CW-1:0] SPR_H_PX = CW'(SPR_HEIGHT << SPR_SCALE);

    typedef enum logic [2:0] {
        IDLE,
        REG_POS,
        ACTIVE,
        WAIT_POS,
        SPR_LINE,
        WAIT_DATA
    } state_t;

    state_t                  state_q, state_d;
    logic signed [CORDW-1:0] sprx_q, sprx_d;
    logic signed [CORDW-1:0] spry_q, spry_d;
    logic [XW-1:0]           bmap_x_q, bmap_x_d;
    logic [YW-1:0]           bmap_y_q, bmap_y_d;
    logic [SW-1:0]           cnt_x_q, cnt_x_d;
    logic [ADDRW-1:0]        pos_q, pos_d;
    logic                    vld_p0;
    logic                    vld_p1_q, vld_p1_d;
    logic                    drawing_q, drawing_d;
    logic [COLRW-1:0]        pix_q, pix_d;

    logic signed [CW-1:0]    sx_w, sy_w, sprx_w, spry_w;
    logic signed [CW-1:0]    dy, x_start, skip;

    function automatic logic [ADDRW-1:0] bmap_addr(
        input logic [YW-1:0] y,
        input logic [XW-1:0] x,
        input logic          hf,
        input logic          vf
    );
        logic [ADDRW-1:0] col;
        logic [ADDRW-1:0] row;
        col = ADDRW'(x);
        row = ADDRW'(y);
        if (hf) col = ADDRW'(SPR_WIDTH - 1) - col;
        if (vf) row = ADDRW'(SPR_HEIGHT - 1) - row;
        return ADDRW'(row * ADDRW'(SPR_WIDTH)) + col;
    endfunction

`ifdef SPRITE_FLIP_EN
    logic hflip_q, hflip_d;
    logic vflip_q, vflip_d;

    always_comb begin
        hflip_d = hflip_q;
        vflip_d = vflip_q;
        if (state_q == REG_POS) begin
            hflip_d = hflip;
            vflip_d = vflip;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hflip_q <= 1'b0;
            vflip_q <= 1'b0;
        end else begin
            hflip_q <= hflip_d;
            vflip_q <= vflip_d;
        end
    end
`else
    logic hflip_q;
    logic vflip_q;
    assign hflip_q = 1'b0;
    assign vflip_q = 1'b0;
`endif

    assign sx_w   = {sx[CORDW-1], sx};
    assign sy_w   = {sy[CORDW-1], sy};
    assign sprx_w = {sprx_q[CORDW-1], sprx_q};
    assign spry_w = {spry_q[CORDW-1], spry_q};
    assign dy     = sy_w - spry_w;

    // A sprite hanging off the left edge starts at the first visible pixel, pre-advanced
    // into the bitmap by the hidden pixel count so the visible part stays aligned.
    assign x_start = sprx_w[CW-1] ? '0 : sprx_w;
    assign skip    = sprx_w[CW-1] ? -sprx_w : '0;

    always_comb begin
        state_d  = state_q;
        sprx_d   = sprx_q;
        spry_d   = spry_q;
        bmap_x_d = bmap_x_q;
        bmap_y_d = bmap_y_q;
        cnt_x_d  = cnt_x_q;
        pos_d    = pos_q;

        case (state_q)
            IDLE: ;
            REG_POS: begin
                sprx_d  = sprx;
                spry_d  = spry;
                state_d = ACTIVE;
            end
            ACTIVE: begin
                if (dy >= 0 && dy < SPR_H_PX) begin
                    bmap_y_d = YW'(dy >>> SPR_SCALE);
                    state_d  = WAIT_POS;
                end else begin
                    state_d  = IDLE;
                end
            end
            WAIT_POS: begin
                if (sprx_w >= H_RES_S || skip >= SPR_W_PX) begin
                    state_d = IDLE;
                end else if (sx_w >= x_start - OFFS) begin
                    bmap_x_d = XW'(skip >>> SPR_SCALE);
                    cnt_x_d  = SW'(skip) & CNT_MAX;
                    pos_d    = bmap_addr(bmap_y_q, bmap_x_d, hflip_q, vflip_q);
                    state_d  = SPR_LINE;
                end
            end
            SPR_LINE: begin
                if (sx_w == H_END) begin
                    state_d = WAIT_DATA;
                end else if (cnt_x_q == CNT_MAX) begin
                    if (bmap_x_q == X_LAST) begin
                        state_d = WAIT_DATA;
                    end else begin
                        cnt_x_d  = '0;
                        bmap_x_d = bmap_x_q + 1'b1;
                        pos_d    = bmap_addr(bmap_y_q, bmap_x_d, hflip_q, vflip_q);
                    end
                end else begin
                    cnt_x_d = cnt_x_q + 1'b1;
                end
            end
            WAIT_DATA: state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        if (line) state_d = REG_POS;
    end

    // p0: address on pos; p1: memory data on data_in; output: registered pix/drawing
    assign vld_p0 = (state_q == SPR_LINE);

    always_comb begin
        vld_p1_d  = vld_p0 && !line;
        drawing_d = vld_p1_q && !line;
        pix_d     = (vld_p1_q && !line) ? data_in : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sprx_q    <= '0;
            spry_q    <= '0;
            bmap_x_q  <= '0;
            bmap_y_q  <= '0;
            cnt_x_q   <= '0;
            pos_q     <= '0;
            vld_p1_q  <= 1'b0;
            drawing_q <= 1'b0;
            pix_q     <= '0;
        end else begin
            state_q   <= state_d;
            sprx_q    <= sprx_d;
            spry_q    <= spry_d;
            bmap_x_q  <= bmap_x_d;
            bmap_y_q  <= bmap_y_d;
            cnt_x_q   <= cnt_x_d;
            pos_q     <= pos_d;
            vld_p1_q  <= vld_p1_d;
            drawing_q <= drawing_d;
            pix_q     <= pix_d;
        end
    end

    assign pos     = pos_q;
    assign pix     = pix_q;
    assign drawing = drawing_q;

endmodule

// File: tb/tb_sprite_rom.sv
// Directed bench for sprite_rom: two instances (scale 0 and scale 1) share one raster scan;
// each bitmap memory returns pos[3:0] one cycle after the address.
`timescale 1ns/1ps
module tb_sprite_rom;

    localparam int CORDW    = 16;
    localparam int H_RES    = 640;
    localparam int H_STA    = -16;
    localparam int LINE_LEN = H_RES - H_STA;
    localparam int COLRW    = 4;
    localparam int ADDRW    = 6;
    localparam int NONE     = -1000;

    logic                    clk   = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    line  = 1'b0;
    logic signed [CORDW-1:0] sx    = '0;
    logic signed [CORDW-1:0] sy    = '0;
    logic signed [CORDW-1:0] sprx  = '0;
    logic signed [CORDW-1:0] spry  = '0;
    logic [COLRW-1:0]        data0 = '0;
    logic [COLRW-1:0]        data1 = '0;
    logic [ADDRW-1:0]        pos0, pos1;
    logic [COLRW-1:0]        pix0, pix1;
    logic                    draw0, draw1;
`ifdef SPRITE_FLIP_EN
    logic                    hflip = 1'b0;
    logic                    vflip = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic       d0_a [LINE_LEN];
    logic       d1_a [LINE_LEN];
    logic [3:0] p0_a [LINE_LEN];
    logic [3:0] p1_a [LINE_LEN];
    logic       rst_d0, rst_d1;
    logic [3:0] rst_p0, rst_p1;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        data0 <= COLRW'(pos0);
        data1 <= COLRW'(pos1);
    end

    sprite_rom #(.SPR_SCALE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .line(line), .sx(sx), .sy(sy),
        .sprx(sprx), .spry(spry), .data_in(data0),
`ifdef SPRITE_FLIP_EN
        .hflip(hflip), .vflip(vflip),
`endif
        .pos(pos0), .pix(pix0), .drawing(draw0)
    );

    sprite_rom #(.SPR_SCALE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .line(line), .sx(sx), .sy(sy),
        .sprx(sprx), .spry(spry), .data_in(data1),
`ifdef SPRITE_FLIP_EN
        .hflip(hflip), .vflip(vflip),
`endif
        .pos(pos1), .pix(pix1), .drawing(draw1)
    );

    // Reference: 8x8 sprite, pixel (r,c) stored at address r*8+c, memory returns address[3:0].
    function automatic logic exp_draw(input int s, input int px, input int py,
                                      input int x, input int y);
        int n;
        n = 8 << s;
        return (y - py >= 0) && (y - py < n) && (x >= px) && (x < px + n) &&
               (x >= 0) && (x < H_RES);
    endfunction

    function automatic logic [3:0] exp_pix(input int s, input int px, input int py,
                                           input int x, input int y,
                                           input logic hf, input logic vf);
        int r, c;
        if (!exp_draw(s, px, py, x, y)) return 4'd0;
        r = (y - py) >> s;
        c = (x - px) >> s;
        if (hf) c = 7 - c;
        if (vf) r = 7 - r;
        return 4'((r * 8 + c) & 15);
    endfunction

    // One raster line from H_STA to H_RES-1 with the line pulse on the first cycle.
    // Outputs are sampled mid-cycle; optional async reset assert/release at given sx.
    task automatic run_line(input int y, input int rst_at, input int rel_at);
        for (int x = H_STA; x < H_RES; x++) begin
            @(posedge clk);
            #1;
            sx   = CORDW'(x);
            line = (x == H_STA);
            if (x == H_STA) sy = CORDW'(y);
            if (x == rel_at) rst_n = 1'b1;
            #4;
            d0_a[x - H_STA] = draw0;
            d1_a[x - H_STA] = draw1;
            p0_a[x - H_STA] = pix0;
            p1_a[x - H_STA] = pix1;
            if (x == rst_at) begin
                rst_n = 1'b0;
                #1;
                rst_d0 = draw0;
                rst_d1 = draw1;
                rst_p0 = pix0;
                rst_p1 = pix1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #5;
        checks += 6;
        if (pos0 !== 6'd0)  begin errors++; $display("FAIL reset_pos0 got %0d want 0", pos0); end
        if (pos1 !== 6'd0)  begin errors++; $display("FAIL reset_pos1 got %0d want 0", pos1); end
        if (pix0 !== 4'd0)  begin errors++; $display("FAIL reset_pix0 got %0d want 0", pix0); end
        if (pix1 !== 4'd0)  begin errors++; $display("FAIL reset_pix1 got %0d want 0", pix1); end
        if (draw0 !== 1'b0) begin errors++; $display("FAIL reset_draw0 got %0b want 0", draw0); end
        if (draw1 !== 1'b0) begin errors++; $display("FAIL reset_draw1 got %0b want 0", draw1); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic_and_scale();
        sprx = 16'sd100;
        spry = 16'sd50;
        for (int y = 48; y < 68; y++) begin
            run_line(y, NONE, NONE);
            for (int i = 0; i < LINE_LEN; i++) begin
                int x;
                logic ed0, ed1;
                logic [3:0] ep0, ep1;
                x = i + H_STA;
                ed0 = exp_draw(0, 100, 50, x, y);
                ed1 = exp_draw(1, 100, 50, x, y);
                ep0 = exp_pix(0, 100, 50, x, y, 1'b0, 1'b0);
                ep1 = exp_pix(1, 100, 50, x, y, 1'b0, 1'b0);
                checks += 2;
                if ({d0_a[i], p0_a[i]} !== {ed0, ep0}) begin
                    errors++;
                    $display("FAIL basic_s0 sy=%0d sx=%0d got draw=%0b pix=%0d want draw=%0b pix=%0d",
                             y, x, d0_a[i], p0_a[i], ed0, ep0);
                end
                if ({d1_a[i], p1_a[i]} !== {ed1, ep1}) begin
                    errors++;
                    $display("FAIL scale_s1 sy=%0d sx=%0d got draw=%0b pix=%0d want draw=%0b pix=%0d",
                             y, x, d1_a[i], p1_a[i], ed1, ep1);
                end
            end
        end
    endtask

    task automatic test_right_edge();
        int px [3] = '{636, 636, 100};
        int ys [3] = '{50, 51, 200};
        spry = 16'sd50;
        for (int k = 0; k < 3; k++) begin
            sprx = CORDW'(px[k]);
            run_line(ys[k], NONE, NONE);
            for (int i = 0; i < LINE_LEN; i++) begin
                int x;
                logic ed0, ed1;
                logic [3:0] ep0, ep1;
                x = i + H_STA;
                ed0 = exp_draw(0, px[k], 50, x, ys[k]);
                ed1 = exp_draw(1, px[k], 50, x, ys[k]);
                ep0 = exp_pix(0, px[k], 50, x, ys[k], 1'b0, 1'b0);
                ep1 = exp_pix(1, px[k], 50, x, ys[k], 1'b0, 1'b0);
                checks += 2;
                if ({d0_a[i], p0_a[i]} !== {ed0, ep0}) begin
                    errors++;
                    $display("FAIL right_s0 sy=%0d sx=%0d got draw=%0b pix=%0d want draw=%0b pix=%0d",
                             ys[k], x, d0_a[i], p0_a[i], ed0, ep0);
                end
                if ({d1_a[i], p1_a[i]} !== {ed1, ep1}) begin
                    errors++;
                    $display("FAIL right_s1 sy=%0d sx=%0d got draw=%0b pix=%0d want draw=%0b pix=%0d",
                             ys[k], x, d1_a[i], p1_a[i], ed1, ep1);
                end
            end
        end
    endtask

    task automatic test_left_clip();
        sprx = -16'sd3;
        spry = -16'sd2;
        for (int y = 0; y < 2; y++) begin
            run_line(y, NONE, NONE);
            for (int i = 0; i < LINE_LEN; i++) begin
                int x;
                logic ed0, ed1;
                logic [3:0] ep0, ep1;
                x = i + H_STA;
                ed0 = exp_draw(0, -3, -2, x, y);
                ed1 = exp_draw(1, -3, -2, x, y);
                ep0 = exp_pix(0, -3, -2, x, y, 1'b0, 1'b0);
                ep1 = exp_pix(1, -3, -2, x, y, 1'b0, 1'b0);
                checks += 2;
                if ({d0_a[i], p0_a[i]} !== {ed0, ep0}) begin
                    errors++;
                    $display("FAIL left_s0 sy=%0d sx=%0d got draw=%0b pix=%0d want draw=%0b pix=%0d",
                             y, x, d0_a[i], p0_a[i], ed0, ep0);
                end
                if ({d1_a[i], p1_a[i]} !== {ed1, ep1}) begin
                    errors++;
                    $display("FAIL left_s1 sy=%0d sx=%0d got draw=%0b pix=%0d want draw=%0b pix=%0d",
                             y, x, d1_a[i], p1_a[i], ed1, ep1);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        sprx = 16'sd100;
        spry = 16'sd50;
        run_line(52, 103, 200);
        checks += 4;
        if (rst_d0 !== 1'b0) begin errors++; $display("FAIL midrst_draw0 got %0b want 0", rst_d0); end
        if (rst_d1 !== 1'b0) begin errors++; $display("FAIL midrst_draw1 got %0b want 0", rst_d1); end
        if (rst_p0 !== 4'd0) begin errors++; $display("FAIL midrst_pix0 got %0d want 0", rst_p0); end
        if (rst_p1 !== 4'd0) begin errors++; $display("FAIL midrst_pix1 got %0d want 0", rst_p1); end
        for (int i = 0; i < LINE_LEN; i++) begin
            int x;
            logic ed0;
            logic [3:0] ep0;
            x = i + H_STA;
            ed0 = (x <= 103) ? exp_draw(0, 100, 50, x, 52) : 1'b0;
            ep0 = (x <= 103) ? exp_pix(0, 100, 50, x, 52, 1'b0, 1'b0) : 4'd0;
            checks++;
            if ({d0_a[i], p0_a[i]} !== {ed0, ep0}) begin
                errors++;
                $display("FAIL midrst_line sx=%0d got draw=%0b pix=%0d want draw=%0b pix=%0d",
                         x, d0_a[i], p0_a[i], ed0, ep0);
            end
        end
        run_line(53, NONE, NONE);
        for (int i = 0; i < LINE_LEN; i++) begin
            int x;
            logic ed0, ed1;
            logic [3:0] ep0, ep1;
            x = i + H_STA;
            ed0 = exp_draw(0, 100, 50, x, 53);
            ed1 = exp_draw(1, 100, 50, x, 53);
            ep0 = exp_pix(0, 100, 50, x, 53, 1'b0, 1'b0);
            ep1 = exp_pix(1, 100, 50, x, 53, 1'b0, 1'b0);
            checks += 2;
            if ({d0_a[i], p0_a[i]} !== {ed0, ep0}) begin
                errors++;
                $display("FAIL after_rst_s0 sx=%0d got draw=%0b pix=%0d want draw=%0b pix=%0d",
                         x, d0_a[i], p0_a[i], ed0, ep0);
            end
            if ({d1_a[i], p1_a[i]} !== {ed1, ep1}) begin
                errors++;
                $display("FAIL after_rst_s1 sx=%0d got draw=%0b pix=%0d want draw=%0b pix=%0d",
                         x, d1_a[i], p1_a[i], ed1, ep1);
            end
        end
    endtask

`ifdef SPRITE_FLIP_EN
    task automatic test_flip();
        sprx  = 16'sd100;
        spry  = 16'sd50;
        hflip = 1'b1;
        vflip = 1'b1;
        run_line(50, NONE, NONE);
        for (int i = 0; i < LINE_LEN; i++) begin
            int x;
            logic ed0, ed1;
            logic [3:0] ep0, ep1;
            x = i + H_STA;
            ed0 = exp_draw(0, 100, 50, x, 50);
            ed1 = exp_draw(1, 100, 50, x, 50);
            ep0 = exp_pix(0, 100, 50, x, 50, 1'b1, 1'b1);
            ep1 = exp_pix(1, 100, 50, x, 50, 1'b1, 1'b1);
            checks += 2;
            if ({d0_a[i], p0_a[i]} !== {ed0, ep0}) begin
                errors++;
                $display("FAIL flip_s0 sx=%0d got draw=%0b pix=%0d want draw=%0b pix=%0d",
                         x, d0_a[i], p0_a[i], ed0, ep0);
            end
            if ({d1_a[i], p1_a[i]} !== {ed1, ep1}) begin
                errors++;
                $display("FAIL flip_s1 sx=%0d got draw=%0b pix=%0d want draw=%0b pix=%0d",
                         x, d1_a[i], p1_a[i], ed1, ep1);
            end
        end
        hflip = 1'b0;
        vflip = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_and_scale();
        test_right_edge();
        test_left_clip();
        test_reset_mid();
`ifdef SPRITE_FLIP_EN
        test_flip();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
